gpu_ram_arbiter: RTL and testbench
==================================

# gpu_ram_arbiter

Shares the single GPU RAM port between the Z80 bus bridge and a second on-chip requester, the graphics/blitter engine (`gfx`). Z80 accesses arrive as one-clock strobes that cannot be stalled, so the block captures them in a one-deep pending slot. The gfx engine uses a valid/ack handshake. The block also tags every RAM read so that each returning read datum is steered to the requester that issued it. It sits between the Z80 bridge and the RAM mux in the GPU clock domain.

## Interface
- `ADDR_BITS`, 20: RAM address width.
- `RD_LATENCY`, 2: cycles from the `ram_rd` strobe to valid `ram_rdata`. Must be ≥1.
- `GPU_CLK` in 1: GPU clock (125 MHz), the only clock.
- `reset` in 1: synchronous, active-high.
- `z80_wr_ena` in 1: one-clock write strobe from the bridge.
- `z80_rd_req` in 1: one-clock read strobe from the bridge.
- `z80_addr` in ADDR_BITS: Z80 address, sampled with either strobe.
- `z80_wdata` in 8: Z80 write data, sampled with `z80_wr_ena`.
- `z80_rd_rdy` out 1: one-clock pulse; `z80_rData` is valid.
- `z80_rData` out 8: Z80 read data, held until the next Z80 read returns.
- `gfx_req` in 1: gfx request valid; held with its fields until acked.
- `gfx_we` in 1: 1 = write, 0 = read.
- `gfx_addr` in ADDR_BITS: gfx address.
- `gfx_wdata` in 8: gfx write data.
- `gfx_ack` out 1: combinational grant; the request is consumed at this edge.
- `gfx_rd_rdy` out 1: one-clock pulse; `gfx_rData` is valid.
- `gfx_rData` out 8: gfx read data, held until the next gfx read returns.
- `ram_addr` out ADDR_BITS: registered RAM address.
- `ram_wdata` out 8: registered RAM write data.
- `ram_we` out 1: registered one-clock write strobe.
- `ram_rd` out 1: registered one-clock read strobe.
- `ram_rdata` in 8: RAM read data, valid RD_LATENCY cycles after `ram_rd`.
- `z80_ovf` out 1: sticky error flag, cleared only by reset.

## Operation
- **Z80 slot.** The slot holds {valid, we, addr, wdata}.
  - A strobe loads the slot at the clock edge.
  - A grant clears the slot.
  - A strobe and a grant in the same cycle: the slot reloads with the new request (load wins over clear).
  - A strobe while the slot is valid and not granted: the new strobe is dropped and `z80_ovf` is set.
  - `z80_wr_ena` and `z80_rd_req` high together: treated as a write, and `z80_ovf` is set.
- **Grant decision** is combinational each cycle. Port states are IDLE, GRANT_Z80 and GRANT_GFX, and the state is re-evaluated every cycle.
  - Slot valid and gfx not requesting → GRANT_Z80.
  - `gfx_req` high and slot empty → GRANT_GFX; `gfx_ack` = 1.
  - Both requesting → resolved per Configuration.
  - Neither requesting → IDLE; `ram_we` = `ram_rd` = 0, and `ram_addr`/`ram_wdata` hold their values.
- **Issue.** The granted request is registered onto the `ram_*` outputs at the edge ending the grant cycle. This allows at most one RAM access per cycle and reaches full throughput (one access per cycle).
- **Read tagging.** This is a RD_LATENCY-stage shift pipeline of {valid, owner}, advanced every cycle and loaded at issue when `ram_rd` is set.
  - When the tail entry is valid, `ram_rdata` is registered into the owner's `*_rData` and the owner's `*_rd_rdy` pulses for one clock.
  - Multiple reads may be in flight at once, and each returns in issue order.
- **Writes** produce no response.
- **Reset values.** All outputs are 0: `ram_*`, both rd_rdy, both rData, `gfx_ack`, `z80_ovf`. The slot is emptied, and a round-robin pointer (when compiled in) points to Z80.
- **Reset mid-operation.** In-flight reads are discarded and no rd_rdy is issued for them. A gfx request held across reset is re-arbitrated after reset.

## Timing
- **Z80 read path** (strobe in cycle n, no contention):
  - Cycle n+1: slot valid and grant.
  - Cycle n+2: `ram_rd` = 1.
  - Cycle n+2+RD_LATENCY: `ram_rdata` valid.
  - Cycle n+3+RD_LATENCY: `z80_rd_rdy` = 1. With the default RD_LATENCY this is 5 cycles after the strobe.
- **Z80 write path:** `ram_we` is high in cycle n+2.
- **gfx request** with `gfx_ack` in cycle m:
  - `ram_*` is driven in cycle m+1.
  - For a read, `gfx_rd_rdy` pulses in cycle m+2+RD_LATENCY.
- `gfx_req` may remain high continuously for back-to-back transfers; each ack consumes exactly one request.
- Worst-case Z80 slot wait under contention is one cycle, so with bridge strobes ≥15 GPU_CLK apart `z80_ovf` never sets in legal operation.

## Configuration
- `ARB_RR_EN` defined: on contention the port alternates between the two requesters.
  - A one-bit pointer records the last winner and flips on every contended grant.
  - An uncontended grant sets the pointer to the requester just granted.
- `ARB_RR_EN` undefined: fixed priority. Z80 always wins contention and the gfx engine waits; no pointer exists.

## Test plan
- **Z80 read, idle port:** `z80_rd_req` at addr 0x00123 with RAM holding 0x5A → `ram_rd` 2 cycles later, `z80_rd_rdy` with 0x5A 5 cycles after the strobe.
- **gfx stream plus Z80 write:** gfx_req held for 8 sequential reads at 0x00200–0x00207, Z80 write of 0xC3 to 0x00204 mid-stream → exactly one-cycle displacement of gfx. Under RR, grants alternate on the contended cycle. `ram_we` carries 0xC3, and all 8 `gfx_rd_rdy` pulses arrive in order with correct data.
- **Overflow:** two `z80_wr_ena` strobes 1 cycle apart while gfx_req is held and RR favours gfx → `z80_ovf` = 1, and only the first write appears on `ram_*`.
- **Illegal strobe pair:** `z80_wr_ena` and `z80_rd_req` in the same cycle → write issued, no `z80_rd_rdy`, `z80_ovf` = 1.
- **Reset with reads in flight:** reset asserted 1 cycle after `ram_rd` with 2 reads in flight → no rd_rdy pulses, all outputs 0 the cycle after reset. A gfx request held through reset is acked in the first cycle after reset deasserts.
- **Tag steering:** interleaved reads with Z80 at 0x00010 (0x11) and gfx at 0x00020 (0x22) issued on consecutive cycles → `z80_rData` = 0x11 and `gfx_rData` = 0x22, each rd_rdy pulsing exactly once.

Source files
------------

// File: rtl/gpu_ram_arbiter.sv
// Purpose : shares the single GPU RAM port between the Z80 bridge (one-deep pending slot)
//           and the gfx/blitter engine (valid/ack), tagging reads so data returns to its issuer.
// Latency : grant -> ram_* one cycle; read grant -> *_rd_rdy in 2+RD_LATENCY cycles.
// Backpressure: gfx waits on gfx_ack; Z80 strobes cannot stall, so a strobe that
//           finds the slot busy is dropped and z80_ovf is latched.
//
// Ports:
//   GPU_CLK, reset            : single clock, synchronous active-high reset
//   z80_wr_ena/z80_rd_req     : one-clock strobes with z80_addr/z80_wdata
//   z80_rd_rdy/z80_rData      : Z80 read return (pulse + held data)
//   gfx_req/gfx_we/gfx_addr/gfx_wdata, gfx_ack : gfx request handshake (ack is combinational)
//   gfx_rd_rdy/gfx_rData      : gfx read return (pulse + held data)
//   ram_addr/ram_wdata/ram_we/ram_rd, ram_rdata : registered RAM port
//   z80_ovf                   : sticky error flag (dropped strobe or write+read together)
// Build option: define ARB_RR_EN for round-robin on contention; otherwise Z80 has fixed priority.

module gpu_ram_arbiter #(
   parameter int ADDR_BITS  = 20,
   parameter int RD_LATENCY = 2
) (
   input  logic                 GPU_CLK,
   input  logic                 reset,
   input  logic                 z80_wr_ena,
   input  logic                 z80_rd_req,
   input  logic [ADDR_BITS-1:0] z80_addr,
   input  logic [7:0]           z80_wdata,
   output logic                 z80_rd_rdy,
   output logic [7:0]           z80_rData,
   input  logic                 gfx_req,
   input  logic                 gfx_we,
   input  logic [ADDR_BITS-1:0] gfx_addr,
   input  logic [7:0]           gfx_wdata,
   output logic                 gfx_ack,
   output logic                 gfx_rd_rdy,
   output logic [7:0]           gfx_rData,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [7:0]           ram_wdata,
   output logic                 ram_we,
   output logic                 ram_rd,
   input  logic [7:0]           ram_rdata,
   output logic                 z80_ovf
);

   typedef enum logic [1:0] {IDLE, GRANT_Z80, GRANT_GFX} port_state_t;

   port_state_t port_state;
   logic        gnt_z80;
   logic        gnt_gfx;

   // Z80 pending slot
   logic                 slot_vld_q, slot_vld_d;
   logic                 slot_we_q, slot_we_d;
   logic [ADDR_BITS-1:0] slot_addr_q, slot_addr_d;
   logic [7:0]           slot_wdata_q, slot_wdata_d;
   logic                 ovf_q, ovf_d;

   // RAM issue registers; ram_own marks which requester owns the read on ram_rd (1 = gfx)
   logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]           ram_wdata_q, ram_wdata_d;
   logic                 ram_we_q, ram_we_d;
   logic                 ram_rd_q, ram_rd_d;
   logic                 ram_own_q, ram_own_d;

   // Read tag pipeline, fed from the registered ram_rd so its tail lines up with ram_rdata
   logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;

   // Read returns
   logic       z80_rd_rdy_q, z80_rd_rdy_d;
   logic [7:0] z80_rdata_q, z80_rdata_d;
   logic       gfx_rd_rdy_q, gfx_rd_rdy_d;
   logic [7:0] gfx_rdata_q, gfx_rdata_d;

`ifdef ARB_RR_EN
   // Last winner: 0 = Z80, 1 = gfx. The other side wins the next contended cycle.
   logic rr_gfx_q, rr_gfx_d;
`endif

   // Grant decision, re-evaluated every cycle; nothing is granted while in reset.
   always_comb begin
      port_state = IDLE;
      if (!reset) begin
         if (slot_vld_q && gfx_req) begin
`ifdef ARB_RR_EN
            port_state = rr_gfx_q ? GRANT_Z80 : GRANT_GFX;
`else
            port_state = GRANT_Z80;
`endif
         end else if (slot_vld_q) begin
            port_state = GRANT_Z80;
         end else if (gfx_req) begin
            port_state = GRANT_GFX;
         end
      end
      gnt_z80 = (port_state == GRANT_Z80);
      gnt_gfx = (port_state == GRANT_GFX);
   end

   assign gfx_ack = gnt_gfx;

   always_comb begin
      // Z80 slot: a strobe loads it if it is empty or being granted this cycle.
      slot_vld_d   = slot_vld_q;
      slot_we_d    = slot_we_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      ovf_d        = ovf_q;
      if (gnt_z80) begin
         slot_vld_d = 1'b0;
      end
      if (z80_wr_ena || z80_rd_req) begin
         if (!slot_vld_q || gnt_z80) begin
            slot_vld_d   = 1'b1;
            slot_we_d    = z80_wr_ena;   // write wins when both strobes fire
            slot_addr_d  = z80_addr;
            slot_wdata_d = z80_wdata;
         end else begin
            ovf_d = 1'b1;
         end
      end
      if (z80_wr_ena && z80_rd_req) begin
         ovf_d = 1'b1;
      end

      // Issue: address/data hold when the port is idle.
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      ram_rd_d    = 1'b0;
      ram_own_d   = 1'b0;
      case (port_state)
         GRANT_Z80: begin
            ram_addr_d = slot_addr_q;
            ram_we_d   = slot_we_q;
            ram_rd_d   = !slot_we_q;
            ram_own_d  = 1'b0;
            if (slot_we_q) begin
               ram_wdata_d = slot_wdata_q;
            end
         end
         GRANT_GFX: begin
            ram_addr_d = gfx_addr;
            ram_we_d   = gfx_we;
            ram_rd_d   = !gfx_we;
            ram_own_d  = 1'b1;
            if (gfx_we) begin
               ram_wdata_d = gfx_wdata;
            end
         end
         default: ;
      endcase

      // Tag shift pipeline
      tag_vld_d[0] = ram_rd_q;
      tag_own_d[0] = ram_own_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_own_d[i] = tag_own_q[i-1];
      end

      // Steer returning data to its owner
      z80_rd_rdy_d = 1'b0;
      gfx_rd_rdy_d = 1'b0;
      z80_rdata_d  = z80_rdata_q;
      gfx_rdata_d  = gfx_rdata_q;
      if (tag_vld_q[RD_LATENCY-1]) begin
         if (tag_own_q[RD_LATENCY-1]) begin
            gfx_rd_rdy_d = 1'b1;
            gfx_rdata_d  = ram_rdata;
         end else begin
            z80_rd_rdy_d = 1'b1;
            z80_rdata_d  = ram_rdata;
         end
      end

`ifdef ARB_RR_EN
      // Recording the winner covers both cases: a contended grant flips the pointer,
      // an uncontended one points it at the requester just served.
      rr_gfx_d = rr_gfx_q;
      if (gnt_gfx) begin
         rr_gfx_d = 1'b1;
      end else if (gnt_z80) begin
         rr_gfx_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge GPU_CLK) begin
      if (reset) begin
         slot_vld_q   <= 1'b0;
         slot_we_q    <= 1'b0;
         slot_addr_q  <= '0;
         slot_wdata_q <= '0;
         ovf_q        <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
         ram_rd_q     <= 1'b0;
         ram_own_q    <= 1'b0;
         tag_vld_q    <= '0;
         tag_own_q    <= '0;
         z80_rd_rdy_q <= 1'b0;
         z80_rdata_q  <= '0;
         gfx_rd_rdy_q <= 1'b0;
         gfx_rdata_q  <= '0;
`ifdef ARB_RR_EN
         rr_gfx_q     <= 1'b0;
`endif
      end else begin
         slot_vld_q   <= slot_vld_d;
         slot_we_q    <= slot_we_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         ovf_q        <= ovf_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
         ram_rd_q     <= ram_rd_d;
         ram_own_q    <= ram_own_d;
         tag_vld_q    <= tag_vld_d;
         tag_own_q    <= tag_own_d;
         z80_rd_rdy_q <= z80_rd_rdy_d;
         z80_rdata_q  <= z80_rdata_d;
         gfx_rd_rdy_q <= gfx_rd_rdy_d;
         gfx_rdata_q  <= gfx_rdata_d;
`ifdef ARB_RR_EN
         rr_gfx_q     <= rr_gfx_d;
`endif
      end
   end

   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign ram_we     = ram_we_q;
   assign ram_rd     = ram_rd_q;
   assign z80_rd_rdy = z80_rd_rdy_q;
   assign z80_rData  = z80_rdata_q;
   assign gfx_rd_rdy = gfx_rd_rdy_q;
   assign gfx_rData  = gfx_rdata_q;
   assign z80_ovf    = ovf_q;

endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// Bench for gpu_ram_arbiter: RAM stub, request-level reference model checked every cycle,
// and directed scenarios with hand-computed literal expectations.

module tb_gpu_ram_arbiter;
   localparam int AB = 20;
   localparam int L  = 2;

   logic          GPU_CLK = 1'b0;
   logic          reset = 1'b1;
   logic          z80_wr_ena = 1'b0;
   logic          z80_rd_req = 1'b0;
   logic [AB-1:0] z80_addr = '0;
   logic [7:0]    z80_wdata = '0;
   logic          z80_rd_rdy;
   logic [7:0]    z80_rData;
   logic          gfx_req = 1'b0;
   logic          gfx_we = 1'b0;
   logic [AB-1:0] gfx_addr = '0;
   logic [7:0]    gfx_wdata = '0;
   logic          gfx_ack;
   logic          gfx_rd_rdy;
   logic [7:0]    gfx_rData;
   logic [AB-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic          ram_we;
   logic          ram_rd;
   logic [7:0]    ram_rdata = 8'hEE;
   logic          z80_ovf;

   gpu_ram_arbiter #(.ADDR_BITS(AB), .RD_LATENCY(L)) dut (
      .GPU_CLK(GPU_CLK), .reset(reset),
      .z80_wr_ena(z80_wr_ena), .z80_rd_req(z80_rd_req), .z80_addr(z80_addr), .z80_wdata(z80_wdata),
      .z80_rd_rdy(z80_rd_rdy), .z80_rData(z80_rData),
      .gfx_req(gfx_req), .gfx_we(gfx_we), .gfx_addr(gfx_addr), .gfx_wdata(gfx_wdata),
      .gfx_ack(gfx_ack), .gfx_rd_rdy(gfx_rd_rdy), .gfx_rData(gfx_rData),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rd(ram_rd),
      .ram_rdata(ram_rdata), .z80_ovf(z80_ovf)
   );

   always #5 GPU_CLK = ~GPU_CLK;

   int n_cmp = 0;
   int n_fail = 0;
   int z_pulses = 0;
   int g_pulses = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_val(input int a);
      logic [7:0] v;
      v = a[7:0] ^ 8'h3C;
      if (a == 'h123) v = 8'h5A;
      if (a == 'h010) v = 8'h11;
      if (a == 'h020) v = 8'h22;
      if (a >= 'h200 && a <= 'h207) v = 8'hA0 + a[7:0];
      return v;
   endfunction

   // ---------------- RAM stub: read data appears L cycles after ram_rd ----------------
   logic [7:0] ram_mem [0:4095];
   logic [7:0] mdl_mem [0:4095];
   logic       hist_vld [0:L];
   logic [7:0] hist_dat [0:L];

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram_mem[i] = init_val(i);
         mdl_mem[i] = init_val(i);
      end
      for (int k = 0; k <= L; k++) begin
         hist_vld[k] = 1'b0;
         hist_dat[k] = 8'h00;
      end
      forever begin
         @(negedge GPU_CLK);
         for (int k = L; k > 0; k--) begin
            hist_vld[k] = hist_vld[k-1];
            hist_dat[k] = hist_dat[k-1];
         end
         hist_vld[0] = ram_rd;
         hist_dat[0] = ram_mem[ram_addr[11:0]];
         if (ram_we) ram_mem[ram_addr[11:0]] = ram_wdata;
         ram_rdata = hist_vld[L] ? hist_dat[L] : 8'hEE;
      end
   end

   always @(negedge GPU_CLK) begin
      if (z80_rd_rdy === 1'b1) z_pulses++;
      if (gfx_rd_rdy === 1'b1) g_pulses++;
   end

   // ---------------- Reference model: requests, winner, outstanding-read queue ----------------
   typedef struct {
      bit         to_gfx;
      int         due;
      logic [7:0] dat;
   } rsp_t;

   rsp_t          rsp_q[$];
   int            cyc = 0;
   bit            m_slot_vld = 0;
   bit            m_slot_we = 0;
   logic [AB-1:0] m_slot_addr = '0;
   logic [7:0]    m_slot_dat = '0;
   bit            m_ovf = 0;
   bit            e_we = 0, e_rd = 0, e_zr = 0, e_gr = 0;
   logic [AB-1:0] e_addr = '0;
   logic [7:0]    e_wdata = '0, e_zd = '0, e_gd = '0;
`ifdef ARB_RR_EN
   bit            m_last_gfx = 0;
`endif

   initial begin : model
      bit   win_z, win_g;
      rsp_t r;
      @(posedge GPU_CLK);
      forever begin
         @(negedge GPU_CLK);
         cyc++;
         // registered outputs expected for this cycle
         chk("ram_we", ram_we, e_we);
         chk("ram_rd", ram_rd, e_rd);
         if (e_we || e_rd) chk("ram_addr", ram_addr, e_addr);
         if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
         chk("z80_rd_rdy", z80_rd_rdy, e_zr);
         chk("z80_rData", z80_rData, e_zd);
         chk("gfx_rd_rdy", gfx_rd_rdy, e_gr);
         chk("gfx_rData", gfx_rData, e_gd);
         chk("z80_ovf", z80_ovf, m_ovf);

         // who owns the port this cycle
         win_z = 0;
         win_g = 0;
         if (!reset) begin
            if (m_slot_vld && gfx_req) begin
`ifdef ARB_RR_EN
               win_z = m_last_gfx;
`else
               win_z = 1;
`endif
               win_g = !win_z;
            end else begin
               win_z = m_slot_vld;
               win_g = gfx_req;
            end
         end
         chk("gfx_ack", gfx_ack, win_g);

         // expectations for the next cycle
         e_we = 0;
         e_rd = 0;
         e_zr = 0;
         e_gr = 0;
         if (reset) begin
            rsp_q.delete();
            m_slot_vld = 0;
            m_ovf = 0;
            e_addr = '0;
            e_wdata = '0;
            e_zd = '0;
            e_gd = '0;
`ifdef ARB_RR_EN
            m_last_gfx = 0;
`endif
         end else begin
            if (win_z || win_g) begin
               e_we   = win_z ? m_slot_we : gfx_we;
               e_rd   = !e_we;
               e_addr = win_z ? m_slot_addr : gfx_addr;
               if (e_we) begin
                  e_wdata = win_z ? m_slot_dat : gfx_wdata;
                  mdl_mem[e_addr[11:0]] = e_wdata;
               end else begin
                  r.to_gfx = win_g;
                  r.due = cyc + 2 + L;
                  r.dat = mdl_mem[e_addr[11:0]];
                  rsp_q.push_back(r);
               end
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc + 1) begin
               r = rsp_q.pop_front();
               if (r.to_gfx) begin
                  e_gr = 1;
                  e_gd = r.dat;
               end else begin
                  e_zr = 1;
                  e_zd = r.dat;
               end
            end
            if (z80_wr_ena && z80_rd_req) m_ovf = 1;
            if (z80_wr_ena || z80_rd_req) begin
               if (!m_slot_vld || win_z) begin
                  m_slot_vld  = 1;
                  m_slot_we   = z80_wr_ena;
                  m_slot_addr = z80_addr;
                  m_slot_dat  = z80_wdata;
               end else begin
                  m_ovf = 1;
               end
            end else if (win_z) begin
               m_slot_vld = 0;
            end
`ifdef ARB_RR_EN
            if (win_z) m_last_gfx = 0;
            if (win_g) m_last_gfx = 1;
`endif
         end
      end
   end

   // ---------------- Directed stimulus ----------------
   task automatic tick();
      @(posedge GPU_CLK);
      #1;
   endtask

   task automatic wait_gfx_ack(input string nm);
      for (int k = 0; k < 20; k++) begin
         @(negedge GPU_CLK);
         if (gfx_ack) return;
         tick();
      end
      n_cmp++;
      n_fail++;
      $display("FAIL %s: gfx_ack never seen, expected within 20 cycles", nm);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int         lat;
      int         ci;
      int         gi;
      int         zp;
      int         gp;
      bit         acked;
      logic [7:0] exp_311;
      bit         exp_ovf;

      // reset state
      repeat (3) tick();
      @(negedge GPU_CLK);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_rd", ram_rd, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_z80_rData", z80_rData, 0);
      chk("rst_gfx_ack", gfx_ack, 0);
      chk("rst_z80_ovf", z80_ovf, 0);
      tick();
      reset = 1'b0;
      repeat (2) tick();

      // T1: Z80 read on an idle port
      z80_rd_req = 1'b1;
      z80_addr = 20'h00123;
      tick();
      z80_rd_req = 1'b0;
      tick();
      @(negedge GPU_CLK);
      chk("t1_ram_rd", ram_rd, 1);
      chk("t1_ram_addr", ram_addr, 20'h00123);
      lat = 0;
      for (int k = 3; k < 20; k++) begin
         tick();
         @(negedge GPU_CLK);
         if (z80_rd_rdy) begin
            lat = k;
            break;
         end
      end
      chk("t1_latency", lat, 5);
      chk("t1_data", z80_rData, 8'h5A);
      repeat (3) tick();

      // T2: gfx stream of 8 reads, Z80 write of 0xC3 to 0x204 mid-stream
      gp = g_pulses;
      ci = 0;
      gi = 0;
      gfx_req = 1'b1;
      gfx_we = 1'b0;
      z80_addr = 20'h00204;
      z80_wdata = 8'hC3;
      while (gi < 8 && ci < 30) begin
         gfx_addr = 20'h00200 + 20'(gi);
         z80_wr_ena = (ci == 3);
         @(negedge GPU_CLK);
         if (gfx_ack) gi++;
         ci++;
         tick();
      end
      gfx_req = 1'b0;
      z80_wr_ena = 1'b0;
      chk("t2_stream_cycles", ci, 9);
      repeat (10) tick();
      chk("t2_gfx_pulses", g_pulses - gp, 8);
      chk("t2_last_gfx_data", gfx_rData, 8'hA7);
      chk("t2_ram_204", ram_mem['h204], 8'hC3);

      // T3: tag steering with interleaved Z80 and gfx reads
      zp = z_pulses;
      gp = g_pulses;
      z80_rd_req = 1'b1;
      z80_addr = 20'h00010;
      tick();
      z80_rd_req = 1'b0;
      tick();
      gfx_req = 1'b1;
      gfx_we = 1'b0;
      gfx_addr = 20'h00020;
      tick();
      gfx_req = 1'b0;
      repeat (10) tick();
      chk("t3_z80_data", z80_rData, 8'h11);
      chk("t3_gfx_data", gfx_rData, 8'h22);
      chk("t3_z80_pulses", z_pulses - zp, 1);
      chk("t3_gfx_pulses", g_pulses - gp, 1);

      // T4: two Z80 writes on consecutive cycles, gfx arriving on the second
      z80_wr_ena = 1'b1;
      z80_addr = 20'h0030F;
      z80_wdata = 8'h55;
      tick();
      z80_wr_ena = 1'b0;
      repeat (3) tick();
      z80_wr_ena = 1'b1;
      z80_addr = 20'h00310;
      z80_wdata = 8'h77;
      tick();
      z80_addr = 20'h00311;
      z80_wdata = 8'h88;
      gfx_req = 1'b1;
      gfx_we = 1'b0;
      gfx_addr = 20'h00300;
      @(negedge GPU_CLK);
      acked = gfx_ack;
      tick();
      z80_wr_ena = 1'b0;
      if (!acked) begin
         wait_gfx_ack("t4_gfx_ack");
         tick();
      end
      gfx_req = 1'b0;
      repeat (8) tick();
`ifdef ARB_RR_EN
      exp_ovf = 1'b1;
      exp_311 = init_val('h311);
`else
      exp_ovf = 1'b0;
      exp_311 = 8'h88;
`endif
      chk("t4_ovf", z80_ovf, exp_ovf);
      chk("t4_ram_310", ram_mem['h310], 8'h77);
      chk("t4_ram_311", ram_mem['h311], exp_311);

      // T6: reset with two gfx reads in flight, request held through reset
      gfx_req = 1'b1;
      gfx_we = 1'b0;
      gfx_addr = 20'h00205;
      tick();
      gfx_addr = 20'h00206;
      tick();
      reset = 1'b1;
      zp = z_pulses;
      gp = g_pulses;
      tick();
      @(negedge GPU_CLK);
      chk("t6_ram_we", ram_we, 0);
      chk("t6_ram_rd", ram_rd, 0);
      chk("t6_ram_addr", ram_addr, 0);
      chk("t6_ram_wdata", ram_wdata, 0);
      chk("t6_z80_rd_rdy", z80_rd_rdy, 0);
      chk("t6_gfx_rd_rdy", gfx_rd_rdy, 0);
      chk("t6_z80_rData", z80_rData, 0);
      chk("t6_gfx_rData", gfx_rData, 0);
      chk("t6_gfx_ack", gfx_ack, 0);
      chk("t6_z80_ovf", z80_ovf, 0);
      tick();
      reset = 1'b0;
      @(negedge GPU_CLK);
      chk("t6_ack_after_reset", gfx_ack, 1);
      tick();
      gfx_req = 1'b0;
      repeat (8) tick();
      chk("t6_gfx_pulses", g_pulses - gp, 1);
      chk("t6_z80_pulses", z_pulses - zp, 0);
      chk("t6_gfx_data", gfx_rData, 8'hA6);

      // T5: write and read strobes together
      zp = z_pulses;
      z80_wr_ena = 1'b1;
      z80_rd_req = 1'b1;
      z80_addr = 20'h00400;
      z80_wdata = 8'h99;
      tick();
      z80_wr_ena = 1'b0;
      z80_rd_req = 1'b0;
      repeat (8) tick();
      chk("t5_no_rd_rdy", z_pulses - zp, 0);
      chk("t5_ovf", z80_ovf, 1);
      chk("t5_ram_400", ram_mem['h400], 8'h99);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
